inst_fetch_buf: RTL and testbench
=================================

// Module: inst_fetch_buf
// PURPOSE
//  Instruction-fetch front end between the PC register and the IF/ID pipeline register.
//  Issues each PC as a request to instruction memory over a req/ready port; in-order responses
//  return on rvalid. Buffers up to DEPTH in-flight/returned fetches in an in-order ring.
//  Delivers {pc, inst} pairs to IF/ID; requests a pipeline stall when memory cannot accept the PC.
// PARAMETERS
//  DEPTH  4   ring entries / max outstanding fetches; power of 2, >=2
//  AW     32  instruction address width (`InstAddrBus)
//  DW     32  instruction width (`InstBus)
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, synchronous, active-high
//  pc           in   AW     current fetch address from PC register
//  ce           in   1      PC valid / chip enable from PC register
//  stall        in   6      pipeline stall vector from ctrl; stall[1] holds IF/ID
//  flush        in   1      discard all buffered and in-flight fetches
//  imem_req     out  1      fetch request valid
//  imem_addr    out  AW     fetch address (= pc)
//  imem_ready   in   1      memory accepts request this cycle
//  imem_rvalid  in   1      response data valid (in request order, >=1 cycle after accept)
//  imem_rdata   in   DW     response instruction
//  out_valid    out  1      head entry holds a returned instruction
//  out_pc       out  AW     head entry PC (0 when !out_valid)
//  out_inst     out  DW     head entry instruction (0 = NOP when !out_valid)
//  stallreq_if  out  1      to ctrl: hold PC, request not accepted
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): head/alloc/fill pointers=0, alloc_cnt=0, drop_cnt=0, all fill flags=0.
//    During rst: imem_req=0, stallreq_if=0, out_valid=0, out_pc=0, out_inst=0.
//  - imem_req = !rst & ce & !flush & (alloc_cnt < DEPTH); imem_addr = pc.
//  - accept = imem_req & imem_ready: allocate entry at alloc ptr, store pc, fill flag=0.
//  - stallreq_if = !rst & ce & !flush & !accept (combinational; ctrl holds pc via stall[0]).
//  - Response: imem_rvalid & drop_cnt!=0 -> response discarded, drop_cnt-1.
//    imem_rvalid & drop_cnt==0 -> write rdata to entry at fill ptr, set fill flag, fill ptr+1.
//    rvalid with no unfilled allocated entry and drop_cnt==0: ignored (protocol violation).
//  - out_valid = head fill flag; out_pc/out_inst from head entry, else zero.
//  - pop = out_valid & (stall[1]==`NonStop) & !flush: head ptr+1, alloc_cnt-1.
//  - Alloc, fill, pop may all occur in one cycle; alloc_cnt nets (+accept -pop).
//  - No bypass: response written at edge t is visible on out_valid from cycle t+1.
//    Min latency accept->out_valid = 2 cycles with 1-cycle memory.
//  - Full: alloc_cnt==DEPTH -> imem_req=0, stallreq_if=1 until a pop frees an entry (next cycle).
//  - Pointers are log2(DEPTH) bits, wrap modulo DEPTH.
//  - Flush: next edge clears ring (alloc_cnt=0, all flags=0, ptrs=head);
//    drop_cnt <= drop_cnt + (allocated-unfilled entries) - (1 if rvalid this cycle and was dropped/filled).
//    An rvalid in the flush cycle is consumed and lost. No accept or pop in a flush cycle.
//  - drop_cnt width log2(DEPTH)+1; never exceeds DEPTH.
// CONFIGURATION
//  IFB_PERF_EN defined: extra outputs perf_fetch_cnt[31:0] (+1 per pop) and perf_stall_cnt[31:0]
//    (+1 per cycle stallreq_if=1); both reset to 0, wrap at 2^32, unaffected by flush.
//  IFB_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  define.v (shared header): `InstAddrBus, `InstBus, `NonStop, `RstEnable, `ChipEnable, add `IfbDepth.
//  One sub-module: ifb_ring -- DEPTH-entry {pc,inst,filled} storage with head/alloc/fill pointers and
//  alloc_cnt; top holds request logic, drop_cnt, stall request, optional perf counters.
// TESTING
//  1 Reset: rst=1 two cycles with ce=1 -> imem_req=0, stallreq_if=0, out_valid=0, out_inst=0.
//  2 Stream: ready=1, 1-cycle rvalid, pc 0,4,8 -> out_pc 0,4,8 on consecutive cycles, first 2 cycles after accept.
//  3 Full: ready=1, rvalid withheld, stall[1]=1 -> 4 accepts then stallreq_if=1; release stall[1] -> one pop, req resumes next cycle.
//  4 Ready low: imem_ready=0 at pc=0x10 -> stallreq_if=1, no alloc; ready=1 next cycle -> accept 0x10 once.
//  5 Flush: 3 accepted, 1 returned, flush -> out_valid=0 next cycle; next 2 rvalids dropped, new pc 0x100 delivered correctly.
//  6 Simultaneous accept+fill+pop at alloc_cnt=DEPTH-1 -> alloc_cnt unchanged, order preserved across pointer wrap.

Source files
------------

// File: rtl/inst_fetch_buf_pkg.sv
// Shared fetch-path constants: legacy header macros plus typed package equivalents.
// Optional feature macro used elsewhere in this slice: IFB_PERF_EN.
`ifndef IFB_DEFINE_SV
`define IFB_DEFINE_SV
`define InstAddrBus 31:0
`define InstBus     31:0
`define NonStop     1'b0
`define RstEnable   1'b1
`define ChipEnable  1'b1
`define IfbDepth    4
`endif

package inst_fetch_buf_pkg;
    localparam int unsigned IFB_DEPTH   = `IfbDepth;
    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam logic        NON_STOP    = `NonStop;
    localparam logic        RST_ENABLE  = `RstEnable;
    localparam logic        CHIP_ENABLE = `ChipEnable;
endpackage

// File: rtl/ifb_ring.sv
// ifb_ring: in-order ring of {pc, inst, filled} entries with head/alloc/fill pointers.
// Entries are allocated at request accept, filled in order by responses, popped from the head.
module ifb_ring import inst_fetch_buf_pkg::*; #(
    parameter int unsigned DEPTH = IFB_DEPTH,
    parameter int unsigned AW    = INST_ADDR_W,
    parameter int unsigned DW    = INST_W,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_alloc,
    input  logic [AW-1:0] i_alloc_pc,
    input  logic          i_fill,
    input  logic [DW-1:0] i_fill_data,
    input  logic          i_pop,
    input  logic          i_clear,
    output logic          o_head_valid,
    output logic [AW-1:0] o_head_pc,
    output logic [DW-1:0] o_head_inst,
    output logic [CW-1:0] o_alloc_cnt,
    output logic [CW-1:0] o_pend_cnt
);
    logic [AW-1:0]    r_pc   [DEPTH];
    logic [DW-1:0]    r_inst [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [PW-1:0]    r_head_ptr;
    logic [PW-1:0]    r_alloc_ptr;
    logic [PW-1:0]    r_fill_ptr;
    logic [CW-1:0]    r_alloc_cnt;
    logic [CW-1:0]    r_pend_cnt;

    // Control state: pointers, counts and fill flags.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_head_ptr  <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_alloc_cnt <= '0;
            r_pend_cnt  <= '0;
            r_filled    <= '0;
        end else if (i_clear) begin
            // Collapse the ring onto the current head; in-flight data is discarded.
            r_alloc_ptr <= r_head_ptr;
            r_fill_ptr  <= r_head_ptr;
            r_alloc_cnt <= '0;
            r_pend_cnt  <= '0;
            r_filled    <= '0;
        end else begin
            // Clearing on pop keeps a stale flag from looking valid once the head wraps.
            if (i_pop) begin
                r_filled[r_head_ptr] <= 1'b0;
                r_head_ptr           <= r_head_ptr + PW'(1);
            end
            if (i_alloc) begin
                r_filled[r_alloc_ptr] <= 1'b0;
                r_alloc_ptr           <= r_alloc_ptr + PW'(1);
            end
            if (i_fill) begin
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + PW'(1);
            end
            r_alloc_cnt <= r_alloc_cnt + CW'(i_alloc) - CW'(i_pop);
            r_pend_cnt  <= r_pend_cnt + CW'(i_alloc) - CW'(i_fill);
        end
    end

    // Entry payload storage; needs no reset since the head is gated by its fill flag.
    always_ff @(posedge clk) begin
        if (rst != RST_ENABLE && !i_clear) begin
            if (i_alloc) r_pc[r_alloc_ptr]  <= i_alloc_pc;
            if (i_fill)  r_inst[r_fill_ptr] <= i_fill_data;
        end
    end

    assign o_head_valid = r_filled[r_head_ptr];
    assign o_head_pc    = r_pc[r_head_ptr];
    assign o_head_inst  = r_inst[r_head_ptr];
    assign o_alloc_cnt  = r_alloc_cnt;
    assign o_pend_cnt   = r_pend_cnt;
endmodule

// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: fetch front end between the PC register and IF/ID.
// Issues PCs to instruction memory, buffers in-order responses, delivers {pc, inst}.
// Optional macro IFB_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module inst_fetch_buf import inst_fetch_buf_pkg::*; #(
    parameter int unsigned DEPTH = IFB_DEPTH,
    parameter int unsigned AW    = INST_ADDR_W,
    parameter int unsigned DW    = INST_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    input  logic          ce,
    input  logic [5:0]    stall,
    input  logic          flush,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          out_valid,
    output logic [AW-1:0] out_pc,
    output logic [DW-1:0] out_inst,
`ifdef IFB_PERF_EN
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_stall_cnt,
`endif
    output logic          stallreq_if
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          w_active;
    logic          w_accept;
    logic          w_fill;
    logic          w_pop;
    logic          w_consumed;
    logic          w_head_valid;
    logic [AW-1:0] w_head_pc;
    logic [DW-1:0] w_head_inst;
    logic [CW-1:0] w_alloc_cnt;
    logic [CW-1:0] w_pend_cnt;
    logic [CW-1:0] w_drop_d;
    logic [CW-1:0] r_drop_cnt;
    logic          w_unused_stall;

    assign w_unused_stall = ^{stall[5:2], stall[0]};

    assign w_active    = (rst != RST_ENABLE) && (ce == CHIP_ENABLE) && !flush;
    assign imem_req    = w_active && (w_alloc_cnt < CW'(DEPTH));
    assign imem_addr   = pc;
    assign w_accept    = imem_req && imem_ready;
    assign stallreq_if = w_active && !w_accept;

    // A response with nothing outstanding to fill and nothing to drop is ignored.
    assign w_fill = (rst != RST_ENABLE) && !flush && imem_rvalid
                    && (r_drop_cnt == '0) && (w_pend_cnt != '0);
    assign w_consumed = imem_rvalid && ((r_drop_cnt != '0) || (w_pend_cnt != '0));

    assign out_valid = (rst != RST_ENABLE) && w_head_valid;
    assign out_pc    = out_valid ? w_head_pc : '0;
    assign out_inst  = out_valid ? w_head_inst : '0;
    assign w_pop     = out_valid && (stall[1] == NON_STOP) && !flush;

    ifb_ring #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ring (
        .clk          (clk),
        .rst          (rst),
        .i_alloc      (w_accept),
        .i_alloc_pc   (pc),
        .i_fill       (w_fill),
        .i_fill_data  (imem_rdata),
        .i_pop        (w_pop),
        .i_clear      (flush),
        .o_head_valid (w_head_valid),
        .o_head_pc    (w_head_pc),
        .o_head_inst  (w_head_inst),
        .o_alloc_cnt  (w_alloc_cnt),
        .o_pend_cnt   (w_pend_cnt)
    );

    // Drop count: flush converts every unfilled entry into a response still owed by memory.
    always_comb begin
        w_drop_d = r_drop_cnt;
        if (flush) begin
            w_drop_d = r_drop_cnt + w_pend_cnt - CW'(w_consumed);
        end else if (imem_rvalid && (r_drop_cnt != '0)) begin
            w_drop_d = r_drop_cnt - CW'(1);
        end
    end

    // Drop count register.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) r_drop_cnt <= '0;
        else                   r_drop_cnt <= w_drop_d;
    end

`ifdef IFB_PERF_EN
    // Performance counters: pops delivered and cycles spent requesting a stall.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(w_pop);
            perf_stall_cnt <= perf_stall_cnt + 32'(stallreq_if);
        end
    end
`endif
endmodule

// File: tb/tb_inst_fetch_buf.sv
// Bench for inst_fetch_buf: directed scenarios then random traffic, checked every cycle
// against a queue-based model of the fetch buffer and an in-order memory responder.
module tb_inst_fetch_buf;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, ce, flush, imem_ready, imem_rvalid;
    logic [31:0] pc, imem_rdata;
    logic [5:0]  stall;
    logic        imem_req, out_valid, stallreq_if;
    logic [31:0] imem_addr, out_pc, out_inst;

    always #5 clk = ~clk;

    inst_fetch_buf dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .ce          (ce),
        .stall       (stall),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .stallreq_if (stallreq_if)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ent_t;

    ent_t        ring_q[$];
    logic [31:0] mem_q[$];
    int          mdrop = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          e_acc = 0;

    function automatic logic [31:0] mem_data(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(bit c, logic [31:0] p, bit rdy, bit rv, bit fl, bit st1);
        ce = c; pc = p; imem_ready = rdy; flush = fl; stall = {4'b0, st1, 1'b0};
        if (rv && mem_q.size() > 0) begin
            imem_rvalid = 1'b1; imem_rdata = mem_data(mem_q[0]);
        end else begin
            imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    // One cycle: check outputs against the model before the edge, then advance the model.
    task automatic step();
        bit act, e_req, e_stl, e_val;
        logic [31:0] e_pc, e_inst;
        int pend;
        #1;
        act   = !rst && ce && !flush;
        e_req = act && (ring_q.size() < DEPTH);
        e_acc = e_req && imem_ready;
        e_stl = act && !e_acc;
        e_val = !rst && ring_q.size() > 0 && ring_q[0].filled;
        e_pc   = e_val ? ring_q[0].pc : 32'h0;
        e_inst = e_val ? ring_q[0].inst : 32'h0;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("imem_addr", imem_addr, pc);
        chk("stallreq_if", 32'(stallreq_if), 32'(e_stl));
        chk("out_valid", 32'(out_valid), 32'(e_val));
        chk("out_pc", out_pc, e_pc);
        chk("out_inst", out_inst, e_inst);
        @(posedge clk);
        if (rst) begin
            ring_q.delete(); mem_q.delete(); mdrop = 0;
        end else if (flush) begin
            pend = 0;
            foreach (ring_q[i]) if (!ring_q[i].filled) pend++;
            if (imem_rvalid) begin
                void'(mem_q.pop_front());
                if (mdrop > 0 || pend > 0) mdrop = mdrop + pend - 1;
                else mdrop = mdrop + pend;
            end else begin
                mdrop = mdrop + pend;
            end
            ring_q.delete();
        end else begin
            if (imem_rvalid) begin
                void'(mem_q.pop_front());
                if (mdrop > 0) mdrop--;
                else begin
                    for (int i = 0; i < ring_q.size(); i++) begin
                        if (!ring_q[i].filled) begin
                            ent_t e = ring_q[i];
                            e.inst = imem_rdata; e.filled = 1;
                            ring_q[i] = e;
                            break;
                        end
                    end
                end
            end
            if (e_val && !stall[1]) void'(ring_q.pop_front());
            if (e_acc) begin
                ent_t n;
                n.pc = pc; n.inst = 32'h0; n.filled = 0;
                ring_q.push_back(n);
                mem_q.push_back(pc);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(bit c, logic [31:0] p, bit rdy, bit rv, bit fl, bit st1);
        drive_in(c, p, rdy, rv, fl, st1);
        step();
    endtask

    task automatic drain(int n);
        for (int i = 0; i < n; i++) drive(0, 32'h0, 1, 1, 0, 0);
    endtask

    logic [31:0] cur_pc;
    bit          c, rdy, rv, fl, st1;

    initial begin
        rst = 1; @(negedge clk);
        // Reset held with ce asserted.
        drive(1, 32'h0, 1, 0, 0, 0);
        drive_in(1, 32'h0, 1, 0, 0, 0); #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_stall", 32'(stallreq_if), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        step();
        rst = 0;

        // Streaming fetch with a one-cycle memory.
        drive(1, 32'h0, 1, 1, 0, 0);
        drive(1, 32'h4, 1, 1, 0, 0);
        drive_in(1, 32'h8, 1, 1, 0, 0); #1;
        chk("stream_first", out_pc, 32'h0);
        step();
        drive_in(0, 32'h0, 1, 1, 0, 0); #1;
        chk("stream_second", out_pc, 32'h4);
        step();
        drain(4);

        // Fill the ring with IF/ID held and no responses.
        for (int i = 0; i < DEPTH; i++) drive(1, 32'h20 + 32'(4 * i), 1, 0, 0, 1);
        drive_in(1, 32'h30, 1, 0, 0, 1); #1;
        chk("full_req", 32'(imem_req), 32'h0);
        chk("full_stall", 32'(stallreq_if), 32'h1);
        step();
        for (int i = 0; i < DEPTH; i++) drive(1, 32'h30, 1, 1, 0, 1);
        drive_in(1, 32'h30, 1, 0, 0, 0); #1;
        chk("full_pop_req", 32'(imem_req), 32'h0);
        chk("full_pop_pc", out_pc, 32'h20);
        step();
        drive_in(1, 32'h30, 1, 0, 0, 1); #1;
        chk("full_resume", 32'(imem_req), 32'h1);
        step();
        drain(8);

        // Memory not ready.
        drive_in(1, 32'h10, 0, 0, 0, 0); #1;
        chk("nrdy_stall", 32'(stallreq_if), 32'h1);
        step();
        drive(1, 32'h10, 1, 0, 0, 0);
        drain(4);

        // Flush with responses still owed.
        drive(1, 32'h40, 1, 0, 0, 1);
        drive(1, 32'h44, 1, 0, 0, 1);
        drive(1, 32'h48, 1, 0, 0, 1);
        drive(0, 32'h0, 1, 1, 0, 1);
        drive(1, 32'h4C, 1, 0, 1, 0);
        drive_in(1, 32'h100, 1, 1, 0, 0); #1;
        chk("flush_valid", 32'(out_valid), 32'h0);
        step();
        drive(0, 32'h0, 1, 1, 0, 0);
        drive(0, 32'h0, 1, 1, 0, 0);
        drive_in(0, 32'h0, 1, 0, 0, 1); #1;
        chk("flush_new_pc", out_pc, 32'h100);
        chk("flush_new_inst", out_inst, mem_data(32'h100));
        step();
        drain(3);

        // Accept, fill and pop in one cycle at DEPTH-1 occupancy.
        drive(1, 32'h200, 1, 0, 0, 1);
        drive(1, 32'h204, 1, 1, 0, 1);
        drive(1, 32'h208, 1, 1, 0, 1);
        drive_in(1, 32'h20C, 1, 1, 0, 0); #1;
        chk("sim_accept", 32'(stallreq_if), 32'h0);
        chk("sim_head", out_pc, 32'h200);
        step();
        drive_in(1, 32'h210, 1, 0, 0, 1); #1;
        chk("sim_cnt_req", 32'(imem_req), 32'h1);
        step();
        drain(10);

        // Random traffic.
        cur_pc = 32'h1000;
        for (int i = 0; i < 800; i++) begin
            c   = ($urandom % 8) != 0;
            rdy = ($urandom % 4) != 0;
            rv  = ($urandom % 3) != 0;
            st1 = ($urandom % 4) == 0;
            fl  = (mdrop == 0) && (($urandom % 25) == 0);
            drive(c, cur_pc, rdy, rv, fl, st1);
            if (e_acc || fl) begin
                if (($urandom % 6) == 0) cur_pc = {$urandom, 2'b00} & 32'h0000_FFFC;
                else cur_pc = cur_pc + 32'h4;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
